exe_alu_arbiter: RTL and testbench
==================================

# exe_alu_arbiter

Two-requester arbiter and result buffer in front of the single shared EXE-stage ALU. The main pipeline (port 0) and the auxiliary address/debug path (port 1) each present an opcode and two operands over valid/ready. The block grants one requester per cycle, evaluates the ALU, and holds the result in a one-entry output register with a source tag until the consumer accepts it. It sits between the ID/EXE boundary and the EXE/MEM boundary.

## Interface
Parameters:
- CNT_W, 16, width of the per-port grant counters (saturating)

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- io_req0_valid  input  1  port 0 request present
- io_req0_ready  output  1  port 0 accepted this cycle (valid && ready = grant)
- io_req0_op  input  4  port 0 ALU opcode
- io_req0_a / io_req0_b  input  32  port 0 operands
- io_req1_valid, io_req1_ready, io_req1_op, io_req1_a, io_req1_b: same for port 1
- io_resp_valid  output  1  result register holds a result
- io_resp_ready  input  1  consumer accepts the result
- io_resp_data  output  32  ALU result
- io_resp_src  output  1  port that produced io_resp_data
- io_grant_cnt0 / io_grant_cnt1  output  CNT_W  saturating count of grants per port

## Operation
- Opcode table (unsigned 4-bit): 1, 8 → a+b (mod 2^32); 2, 10 → a >> b[4:0] logical; 3 → a >>> b[4:0] arithmetic; 9 → {31'b0, signed(a) < signed(b)}; any other → 32'h0. Only b[4:0] is used for shifts.
- accept = !io_resp_valid || io_resp_ready (output register free or draining this cycle).
- Grant only when accept=1. If one port valid, it wins. If both valid, arbitration per Configuration.
- io_reqN_ready = accept && (port N is the winner); ready never asserted for a non-winner, never both ready in one cycle.
- On grant: io_resp_data ← ALU(op,a,b) of winner, io_resp_src ← winner, io_resp_valid ← 1, last_grant ← winner, grant counter of winner += 1 unless at 2^CNT_W−1.
- On io_resp_valid && io_resp_ready with no new grant: io_resp_valid ← 0; data/src hold last value.
- While io_resp_valid && !io_resp_ready: data and src stable, both ready low.
- ready depends combinationally on io_resp_ready and valids (no combinational path from data/op inputs to ready).

## Timing
- Latency: grant in cycle N → io_resp_valid/data in cycle N+1.
- Throughput: one result per cycle when consumer holds io_resp_ready=1.
- Reset values: io_resp_valid=0, io_resp_data=0, io_resp_src=0, counters=0, last_grant=1 (port 0 wins first contention). Reset asserted mid-transfer drops the held result; no grant while reset=1.
- Simultaneous drain and grant in one cycle: register reloads, io_resp_valid stays 1.
- Counter saturation: stays at all-ones, no wrap.

## Configuration
- EXE_ARB_RR_EN defined: round-robin on contention; winner = port not equal to last_grant.
- Not defined: fixed priority, port 0 always wins contention; last_grant still tracked but unused for arbitration.

## Structure
- Shared package: 4-bit opcode constants (ADD=1, SRL=2, SRA=3, SLT=9, SRL_ALT=10, ADD_ALT=8), XLEN=32, port-index constants.
- One sub-module: exe_alu_core, purely combinational opcode-table evaluator (op, a, b → result); arbiter, output register and counters in top.

## Test plan
- Reset, port 0 only, op=1, a=5, b=7, resp_ready=1 → next cycle resp_valid=1, data=12, src=0, cnt0=1.
- Port 1 op=3, a=32'h80000000, b=4 → data=32'hF8000000, src=1; op=9 a=−1 b=1 → data=1; op=5 → data=0.
- Both valid every cycle, resp_ready=1, RR enabled → grants alternate 0,1,0,1; without macro → only port 0 granted, io_req1_ready stays 0.
- resp_ready=0 for 3 cycles with result held → data/src stable, both ready low; release → new grant same cycle as drain, resp_valid stays 1.
- reset asserted while resp_valid=1 → next cycle resp_valid=0, counters=0, first contention afterwards goes to port 0.
- CNT_W=2, 5 grants to port 0 → cnt0 saturates at 3.

Source files
------------

// File: rtl/exe_alu_arbiter_pkg.sv
// Shared constants and types for the EXE-stage ALU arbiter: opcodes, datapath width,
// requester port indices and the per-request operand bundle.
package exe_alu_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [3:0] OP_SRL     = 4'd2;
  localparam logic [3:0] OP_SRA     = 4'd3;
  localparam logic [3:0] OP_ADD_ALT = 4'd8;
  localparam logic [3:0] OP_SLT     = 4'd9;
  localparam logic [3:0] OP_SRL_ALT = 4'd10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/exe_alu_core.sv
// Purely combinational ALU opcode-table evaluator; unknown opcodes produce zero.
// Shifts use only the low five bits of b.
module exe_alu_core
  import exe_alu_arbiter_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;

  always_comb begin
    result_o = '0;
    shamt    = b_i[4:0];
    case (op_i)
      OP_ADD, OP_ADD_ALT: result_o = a_i + b_i;
      OP_SRL, OP_SRL_ALT: result_o = a_i >> shamt;
      OP_SRA:             result_o = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:             result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default:            result_o = '0;
    endcase
  end

endmodule

// File: rtl/exe_alu_arbiter.sv
// Two-requester arbiter, one-entry result register and saturating grant counters in front
// of the shared EXE ALU. Define EXE_ARB_RR_EN for round-robin contention, else port 0 wins.
module exe_alu_arbiter
  import exe_alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req0_valid,
  output logic             io_req0_ready,
  input  logic [3:0]       io_req0_op,
  input  logic [XLEN-1:0]  io_req0_a,
  input  logic [XLEN-1:0]  io_req0_b,
  input  logic             io_req1_valid,
  output logic             io_req1_ready,
  input  logic [3:0]       io_req1_op,
  input  logic [XLEN-1:0]  io_req1_a,
  input  logic [XLEN-1:0]  io_req1_b,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [XLEN-1:0]  io_resp_data,
  output logic             io_resp_src,
  output logic [CNT_W-1:0] io_grant_cnt0,
  output logic [CNT_W-1:0] io_grant_cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]  resp_data_q,  resp_data_d;
  logic             resp_src_q,   resp_src_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             accept;
  logic             winner;
  logic             grant;
  alu_req_t         req0, req1, sel_req;
  logic [XLEN-1:0]  alu_result;

  assign req0 = '{op: io_req0_op, a: io_req0_a, b: io_req0_b};
  assign req1 = '{op: io_req1_op, a: io_req1_a, b: io_req1_b};

  assign accept = !resp_valid_q || io_resp_ready;

`ifdef EXE_ARB_RR_EN
  always_comb begin
    if (io_req0_valid && io_req1_valid) winner = ~last_grant_q;
    else                                winner = io_req1_valid ? PORT1 : PORT0;
  end
`else
  // Fixed priority still tracks last_grant so both builds keep identical state.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
  assign winner = io_req0_valid ? PORT0 : PORT1;
`endif

  // Ready never depends on operand/opcode inputs, only on valids and the consumer.
  assign grant         = !reset && accept && (io_req0_valid || io_req1_valid);
  assign io_req0_ready = grant && (winner == PORT0);
  assign io_req1_ready = grant && (winner == PORT1);

  assign sel_req = (winner == PORT1) ? req1 : req0;

  exe_alu_core u_alu (
    .op_i     (sel_req.op),
    .a_i      (sel_req.a),
    .b_i      (sel_req.b),
    .result_o (alu_result)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_src_d   = resp_src_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (grant) begin
      resp_valid_d = 1'b1;
      resp_data_d  = alu_result;
      resp_src_d   = winner;
      last_grant_d = winner;
      if (winner == PORT0 && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_ONE;
      if (winner == PORT1 && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_ONE;
    end else if (io_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_src_q   <= PORT0;
      last_grant_q <= PORT1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_src_q   <= resp_src_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign io_resp_valid = resp_valid_q;
  assign io_resp_data  = resp_data_q;
  assign io_resp_src   = resp_src_q;
  assign io_grant_cnt0 = cnt0_q;
  assign io_grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_exe_alu_arbiter.sv
// Self-checking bench for exe_alu_arbiter: directed scenarios plus random traffic against
// a transaction-level model; a second instance with CNT_W=2 exercises counter saturation.
module tb_exe_alu_arbiter;

`ifdef EXE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, resp_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        req0_ready, req1_ready, resp_valid, resp_src;
  logic [31:0] resp_data;
  logic [15:0] cnt0, cnt1;

  logic        s_req0_ready, s_req1_ready, s_resp_valid, s_resp_src;
  logic [31:0] s_resp_data;
  logic [1:0]  s_cnt0, s_cnt1;

  int total = 0;
  int bad   = 0;

  // transaction-level model state
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_src;
  bit          m_last;
  int          m_cnt0, m_cnt1;
  int          exp_w;
  bit          exp_r0, exp_r1;

  always #5 clock = ~clock;

  exe_alu_arbiter #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .io_req0_valid(req0_valid), .io_req0_ready(req0_ready), .io_req0_op(req0_op),
    .io_req0_a(req0_a), .io_req0_b(req0_b),
    .io_req1_valid(req1_valid), .io_req1_ready(req1_ready), .io_req1_op(req1_op),
    .io_req1_a(req1_a), .io_req1_b(req1_b),
    .io_resp_valid(resp_valid), .io_resp_ready(resp_ready), .io_resp_data(resp_data),
    .io_resp_src(resp_src), .io_grant_cnt0(cnt0), .io_grant_cnt1(cnt1)
  );

  exe_alu_arbiter #(.CNT_W(2)) dut_s (
    .clock(clock), .reset(reset),
    .io_req0_valid(req0_valid), .io_req0_ready(s_req0_ready), .io_req0_op(req0_op),
    .io_req0_a(req0_a), .io_req0_b(req0_b),
    .io_req1_valid(req1_valid), .io_req1_ready(s_req1_ready), .io_req1_op(req1_op),
    .io_req1_a(req1_a), .io_req1_b(req1_b),
    .io_resp_valid(s_resp_valid), .io_resp_ready(resp_ready), .io_resp_data(s_resp_data),
    .io_resp_src(s_resp_src), .io_grant_cnt0(s_cnt0), .io_grant_cnt1(s_cnt1)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = b[4:0];
    case (op)
      4'd1, 4'd8:  r = a + b;
      4'd2, 4'd10: r = a >> sh;
      4'd3: begin
        r = a >> sh;
        if (a[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd9:    r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat16(input int c);
    return (c > 65535) ? 16'hFFFF : c[15:0];
  endfunction

  function automatic logic [1:0] sat2(input int c);
    return (c > 3) ? 2'd3 : c[1:0];
  endfunction

  task automatic drive(input bit v0, input logic [3:0] op0, input logic [31:0] a0,
                       input logic [31:0] b0, input bit v1, input logic [3:0] op1,
                       input logic [31:0] a1, input logic [31:0] b1, input bit rr);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    resp_ready = rr;
  endtask

  task automatic predict();
    bit acc;
    acc   = !m_valid || resp_ready;
    exp_w = -1;
    if (!reset && acc) begin
      if (req0_valid && req1_valid) exp_w = (RR && m_last == 1'b0) ? 1 : 0;
      else if (req0_valid)          exp_w = 0;
      else if (req1_valid)          exp_w = 1;
    end
    exp_r0 = (exp_w == 0);
    exp_r1 = (exp_w == 1);
  endtask

  task automatic advance();
    @(posedge clock);
    if (reset) begin
      m_valid = 0; m_data = '0; m_src = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    end else if (exp_w >= 0) begin
      m_valid = 1;
      m_data  = (exp_w == 0) ? ref_alu(req0_op, req0_a, req0_b)
                             : ref_alu(req1_op, req1_a, req1_b);
      m_src   = (exp_w == 1);
      m_last  = (exp_w == 1);
      if (exp_w == 0) m_cnt0++;
      else            m_cnt1++;
    end else if (resp_ready) begin
      m_valid = 0;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    @(negedge clock);
    predict(); advance();
    predict(); advance();
    reset = 1'b0;
    predict();
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
    total++; if (resp_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", resp_data); end
    total++; if (resp_src !== 1'b0) begin bad++; $display("FAIL reset_src got=%b want=0", resp_src); end
    total++; if ({cnt0, cnt1} !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h/%h want=0/0", cnt0, cnt1); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_port0_add();
    drive(1, 4'd1, 32'd5, 32'd7, 0, 4'd0, 0, 0, 1);
    predict();
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL p0_ready got=%b want=10", {req0_ready, req1_ready}); end
    advance();
    drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    predict();
    #1;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL p0_valid got=%b want=1", resp_valid); end
    total++; if (resp_data !== 32'd12) begin bad++; $display("FAIL p0_data got=%h want=0000000c", resp_data); end
    total++; if (resp_src !== 1'b0) begin bad++; $display("FAIL p0_src got=%b want=0", resp_src); end
    total++; if (cnt0 !== 16'd1) begin bad++; $display("FAIL p0_cnt0 got=%0d want=1", cnt0); end
    advance();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL p0_drain got=%b want=0", resp_valid); end
  endtask

  task automatic test_port1_ops();
    logic [3:0]  ops [6] = '{4'd3, 4'd9, 4'd5, 4'd10, 4'd8, 4'd2};
    logic [31:0] as  [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h123, 32'hF0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'd4, 32'd1, 32'h456, 32'd36, 32'd2, 32'd31};
    logic [31:0] ex  [6] = '{32'hF800_0000, 32'd1, 32'd0, 32'h0F, 32'd1, 32'd1};
    for (int i = 0; i < 6; i++) begin
      drive(0, 4'd0, 0, 0, 1, ops[i], as[i], bs[i], 1);
      predict();
      #1;
      total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL p1_ready[%0d] got=%b want=01", i, {req0_ready, req1_ready}); end
      advance();
      total++; if (resp_data !== ex[i] || resp_src !== 1'b1 || resp_valid !== 1'b1)
        begin bad++; $display("FAIL p1_op[%0d] got=%h/src%b want=%h/src1", i, resp_data, resp_src, ex[i]); end
    end
  endtask

  task automatic test_contention();
    reset = 1'b1;
    drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    predict(); advance();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bit w1;
      w1 = RR && (k % 2 == 1);
      drive(1, 4'd1, k, 32'd100, 1, 4'd1, k, 32'd200, 1);
      predict();
      #1;
      total++; if ({req0_ready, req1_ready} !== {!w1, w1})
        begin bad++; $display("FAIL cont_ready[%0d] got=%b want=%b", k, {req0_ready, req1_ready}, {!w1, w1}); end
      advance();
      total++; if (resp_src !== w1 || resp_data !== (w1 ? k + 200 : k + 100))
        begin bad++; $display("FAIL cont_resp[%0d] got=src%b/%h want=src%b", k, resp_src, resp_data, w1); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_d;
    bit          held_s;
    held_d = m_data;
    held_s = m_src;
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'd8, 32'h1000 + k, 32'd1, 1, 4'd3, 32'hF000_0000, k, 0);
      predict();
      #1;
      total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=00", k, {req0_ready, req1_ready}); end
      total++; if (resp_valid !== 1'b1 || resp_data !== held_d || resp_src !== held_s)
        begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b want=1/%h/%b", k, resp_valid, resp_data, resp_src, held_d, held_s); end
      advance();
    end
    drive(1, 4'd8, 32'h2000, 32'd3, 1, 4'd3, 32'hF000_0000, 32'd8, 1);
    predict();
    #1;
    total++; if ({req0_ready, req1_ready} !== {exp_r0, exp_r1} || exp_w < 0)
      begin bad++; $display("FAIL bp_release got=%b want=%b", {req0_ready, req1_ready}, {exp_r0, exp_r1}); end
    advance();
    total++; if (resp_valid !== 1'b1 || resp_data !== m_data || resp_src !== m_src)
      begin bad++; $display("FAIL bp_reload got=%b/%h/%b want=1/%h/%b", resp_valid, resp_data, resp_src, m_data, m_src); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    drive(1, 4'd1, 32'd1, 32'd1, 1, 4'd1, 32'd2, 32'd2, 0);
    predict();
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", {req0_ready, req1_ready}); end
    advance();
    total++; if (resp_valid !== 1'b0 || resp_data !== 32'd0 || {cnt0, cnt1} !== 32'd0)
      begin bad++; $display("FAIL rst_mid got=%b/%h/%h/%h want=0/0/0/0", resp_valid, resp_data, cnt0, cnt1); end
    reset = 1'b0;
    resp_ready = 1'b1;
    predict();
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rst_first got=%b want=10", {req0_ready, req1_ready}); end
    advance();
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    drive(1, 4'd1, 32'd1, 32'd2, 0, 4'd0, 0, 0, 1);
    predict(); advance();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin predict(); advance(); end
    total++; if (s_cnt0 !== 2'd3) begin bad++; $display("FAIL sat_cnt0 got=%0d want=3", s_cnt0); end
    total++; if (cnt0 !== 16'd5) begin bad++; $display("FAIL wide_cnt0 got=%0d want=5", cnt0); end
  endtask

  task automatic test_random();
    logic [3:0] pool [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd5, 4'd15};
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 1), pool[$urandom_range(0, 8)], $urandom,
            ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
            $urandom_range(0, 1), pool[$urandom_range(0, 8)], $urandom,
            ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
            $urandom_range(0, 9) < 7);
      predict();
      #1;
      total++; if ({req0_ready, req1_ready} !== {exp_r0, exp_r1})
        begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", k, {req0_ready, req1_ready}, {exp_r0, exp_r1}); end
      total++; if (resp_valid !== m_valid || resp_data !== m_data || resp_src !== m_src)
        begin bad++; $display("FAIL rnd_resp[%0d] got=%b/%h/%b want=%b/%h/%b", k, resp_valid, resp_data, resp_src, m_valid, m_data, m_src); end
      total++; if (cnt0 !== sat16(m_cnt0) || cnt1 !== sat16(m_cnt1))
        begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d want=%0d/%0d", k, cnt0, cnt1, sat16(m_cnt0), sat16(m_cnt1)); end
      total++; if ({s_req0_ready, s_req1_ready, s_resp_valid, s_resp_src, s_resp_data, s_cnt0, s_cnt1}
                   !== {exp_r0, exp_r1, m_valid, m_src, m_data, sat2(m_cnt0), sat2(m_cnt1)})
        begin bad++; $display("FAIL rnd_small[%0d] got=%b%b%b%b/%h/%0d/%0d want=%b%b%b%b/%h/%0d/%0d", k,
                              s_req0_ready, s_req1_ready, s_resp_valid, s_resp_src, s_resp_data, s_cnt0, s_cnt1,
                              exp_r0, exp_r1, m_valid, m_src, m_data, sat2(m_cnt0), sat2(m_cnt1)); end
      advance();
    end
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_src = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    exp_w = -1; exp_r0 = 0; exp_r1 = 0;
    test_reset();
    test_port0_add();
    test_port1_ops();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
